// File: rtl/l15_data_array_ctrl.sv
// l15_data_array_ctrl: merges line refills and word fetches onto the single-port L1.5 data array,
// returning fetch data in order through a 2-entry response buffer.
module l15_data_array_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 7,
   parameter int LINE_BEATS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fetch_req_i,
   input  logic [ADDR_WIDTH-1:0]   fetch_addr_i,
   output logic                    fetch_gnt_o,
   output logic                    fetch_rvalid_o,
   output logic [DATA_WIDTH-1:0]   fetch_rdata_o,
   input  logic                    fetch_rready_i,
   input  logic                    refill_valid_i,
   input  logic [ADDR_WIDTH-1:0]   refill_addr_i,
   input  logic [DATA_WIDTH-1:0]   refill_data_i,
   output logic                    refill_ready_o,
   output logic                    refill_done_o,
   output logic                    busy_o,
   output logic                    ram_req_o,
   output logic                    ram_write_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
   localparam int OW = $clog2(LINE_BEATS);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BEATS - 1);
   typedef enum logic {IDLE, REFILL} state_t;
   state_t state_q, state_d;
   logic [OW-1:0] cnt_q, cnt_d, beat_idx;
   logic [ADDR_WIDTH-1:0] base_q, base_d, line_base;
   logic pend_q, pend_d, done_q, done_d;
   logic [1:0] count_q, count_d;
   logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [2];
   logic [DATA_WIDTH-1:0] mem_d [2];
   logic wr, last, pop, push;
   logic [2:0] occ;
   always_comb begin
      wr = refill_valid_i & ~rst;
      beat_idx = (state_q == IDLE) ? '0 : cnt_q;
      line_base = (state_q == IDLE) ? (refill_addr_i & ~LINE_MASK) : base_q;
      last = wr & (beat_idx == OW'(LINE_BEATS - 1));
      fetch_rvalid_o = count_q != 2'd0;
      fetch_rdata_o = fetch_rvalid_o ? mem_q[rd_ptr_q] : '0;
      pop = fetch_rvalid_o & fetch_rready_i;
      push = pend_q;
      // the read issued last cycle already owns a slot, so occupancy includes it
      occ = 3'(count_q) + 3'(pend_q) - 3'(pop);
      fetch_gnt_o = fetch_req_i & ~rst & (state_q == IDLE) & ~refill_valid_i & (occ < 3'd2);
      refill_ready_o = ~rst;
      refill_done_o = done_q;
      busy_o = (state_q == REFILL) | pend_q | fetch_rvalid_o;
      ram_req_o = wr | fetch_gnt_o;
      ram_write_o = wr;
      ram_addr_o = wr ? (line_base | ADDR_WIDTH'(beat_idx)) : fetch_gnt_o ? fetch_addr_i : '0;
      ram_wdata_o = wr ? refill_data_i : '0;
      ram_be_o = wr ? '1 : '0;
      state_d = last ? IDLE : wr ? REFILL : state_q;
      cnt_d = wr ? beat_idx + 1'b1 : cnt_q;
      base_d = wr ? line_base : base_q;
      done_d = last;
      pend_d = fetch_gnt_o;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      mem_d = mem_q;
      mem_d[wr_ptr_q] = push ? ram_rdata_i : mem_q[wr_ptr_q];
   end
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         base_q <= '0;
         pend_q <= 1'b0;
         done_q <= 1'b0;
         count_q <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         base_q <= base_d;
         pend_q <= pend_d;
         done_q <= done_d;
         count_q <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end
endmodule

// File: tb/tb_l15_data_array_ctrl.sv
// tb_l15_data_array_ctrl: directed table, corner sequences and random traffic against a transaction-level model.
module tb_l15_data_array_ctrl;
   localparam int LB = 4;
   logic clk = 1'b0, rst;
   logic fetch_req_i, fetch_gnt_o, fetch_rvalid_o, fetch_rready_i;
   logic [6:0] fetch_addr_i, refill_addr_i, ram_addr_o;
   logic [63:0] fetch_rdata_o, refill_data_i, ram_wdata_o, ram_rdata_i;
   logic refill_valid_i, refill_ready_o, refill_done_o, busy_o, ram_req_o, ram_write_o;
   logic [7:0] ram_be_o;
   int errors = 0, checks = 0;

   l15_data_array_ctrl dut (
      .clk(clk), .rst(rst),
      .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
      .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o), .fetch_rready_i(fetch_rready_i),
      .refill_valid_i(refill_valid_i), .refill_addr_i(refill_addr_i), .refill_data_i(refill_data_i),
      .refill_ready_o(refill_ready_o), .refill_done_o(refill_done_o), .busy_o(busy_o),
      .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pat(input int a);
      return {32'hDEAD_BEEF, 32'(a)};
   endfunction

   // array emulation; contents return to a known pattern whenever rst is high
   logic [63:0] tbmem [128];
   always @(posedge clk) begin
      if (rst) for (int i = 0; i < 128; i++) tbmem[i] <= pat(i);
      else if (ram_req_o && ram_write_o) tbmem[ram_addr_o] <= ram_wdata_o;
      if (ram_req_o && !ram_write_o) ram_rdata_i <= tbmem[ram_addr_o];
   end

   // reference model: array image, outstanding responses with grant time, refill progress
   typedef struct { logic [63:0] d; int t; } resp_t;
   resp_t q[$];
   logic [63:0] refmem [128];
   int cyc = 0, n = 0, base = 0;
   bit in_ref = 0, done_e = 0;
   logic obs_gnt, obs_rv, obs_done, obs_busy, obs_req, obs_wr;
   logic [6:0] obs_addr;
   logic [63:0] obs_rd;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic rv, input logic [6:0] ra, input logic [63:0] rd,
                        input logic rq, input logic [6:0] fa, input logic rr);
      bit rv_e, pop, gnt_e, wr_e, req_e;
      logic [6:0] addr_e;
      @(negedge clk);
      rst = r; refill_valid_i = rv; refill_addr_i = ra; refill_data_i = rd;
      fetch_req_i = rq; fetch_addr_i = fa; fetch_rready_i = rr;
      #1;
      obs_gnt = fetch_gnt_o; obs_rv = fetch_rvalid_o; obs_done = refill_done_o; obs_busy = busy_o;
      obs_req = ram_req_o; obs_wr = ram_write_o; obs_addr = ram_addr_o; obs_rd = fetch_rdata_o;
      rv_e = q.size() > 0 && q[0].t + 2 <= cyc;
      pop = rv_e & rr;
      gnt_e = rq & !r & !in_ref & !rv & (q.size() - int'(pop) < 2);
      wr_e = rv & !r;
      req_e = wr_e | gnt_e;
      addr_e = wr_e ? (in_ref ? 7'(base + n) : (ra & ~7'(LB - 1))) : fa;
      chk("gnt", fetch_gnt_o, gnt_e);
      chk("rvalid", fetch_rvalid_o, rv_e);
      if (rv_e) chk("rdata", fetch_rdata_o, q[0].d);
      chk("refill_ready", refill_ready_o, !r);
      chk("done", refill_done_o, done_e);
      chk("busy", busy_o, in_ref | (q.size() != 0));
      chk("ram_req", ram_req_o, req_e);
      if (req_e) begin
         chk("ram_write", ram_write_o, wr_e);
         chk("ram_addr", ram_addr_o, addr_e);
      end
      if (wr_e) begin
         chk("ram_wdata", ram_wdata_o, rd);
         chk("ram_be", ram_be_o, 8'hFF);
      end
      if (r) begin
         q.delete(); in_ref = 0; n = 0; done_e = 0;
         for (int i = 0; i < 128; i++) refmem[i] = pat(i);
      end else begin
         done_e = 0;
         if (wr_e) begin
            refmem[addr_e] = rd;
            if (!in_ref) begin base = int'(ra) & ~(LB - 1); in_ref = 1; n = 1; end
            else n++;
            if (n == LB) begin in_ref = 0; n = 0; done_e = 1; end
         end
         if (pop) void'(q.pop_front());
         if (gnt_e) q.push_back('{refmem[fa], cyc});
      end
      cyc++;
   endtask

   typedef struct {
      logic rv; logic [6:0] ra; logic [63:0] rd;
      logic rq; logic [6:0] fa; logic rr;
      logic e_gnt, e_req, e_wr; logic [6:0] e_addr;
      logic e_rv; logic [63:0] e_rd; logic e_dn, e_bz;
   } vec_t;
   vec_t tbl [14];
   localparam logic [63:0] D0 = 64'hA0A0_0000_1111_0000, D1 = 64'hA1A1_0000_2222_0001;
   localparam logic [63:0] D2 = 64'hA2A2_0000_3333_0002, D3 = 64'hA3A3_0000_4444_0003;

   initial begin
      int issued;
      tbl[0]  = '{0, 0, 0, 1, 7'h05, 1, 1, 1, 0, 7'h05, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 64'hDEAD_BEEF_0000_0005, 0, 1};
      tbl[3]  = '{1, 7'h13, D0, 0, 0, 1, 0, 1, 1, 7'h10, 0, 0, 0, 0};
      tbl[4]  = '{1, 0, D1, 0, 0, 1, 0, 1, 1, 7'h11, 0, 0, 0, 1};
      tbl[5]  = '{1, 0, D2, 0, 0, 1, 0, 1, 1, 7'h12, 0, 0, 0, 1};
      tbl[6]  = '{1, 0, D3, 0, 0, 1, 0, 1, 1, 7'h13, 0, 0, 0, 1};
      tbl[7]  = '{0, 0, 0, 1, 7'h10, 1, 1, 1, 0, 7'h10, 0, 0, 1, 0};
      tbl[8]  = '{0, 0, 0, 1, 7'h11, 1, 1, 1, 0, 7'h11, 0, 0, 0, 1};
      tbl[9]  = '{0, 0, 0, 1, 7'h12, 1, 1, 1, 0, 7'h12, 1, D0, 0, 1};
      tbl[10] = '{0, 0, 0, 1, 7'h13, 1, 1, 1, 0, 7'h13, 1, D1, 0, 1};
      tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, D2, 0, 1};
      tbl[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, D3, 0, 1};
      tbl[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      repeat (3) cycle(1, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      chk("reset_rvalid", obs_rv, 0);
      chk("reset_done", obs_done, 0);
      chk("reset_busy", obs_busy, 0);
      chk("reset_rdata", obs_rd, 0);
      for (int i = 0; i < 14; i++) begin
         cycle(0, tbl[i].rv, tbl[i].ra, tbl[i].rd, tbl[i].rq, tbl[i].fa, tbl[i].rr);
         chk($sformatf("tbl%0d_gnt", i), obs_gnt, tbl[i].e_gnt);
         chk($sformatf("tbl%0d_req", i), obs_req, tbl[i].e_req);
         if (tbl[i].e_req) begin
            chk($sformatf("tbl%0d_wr", i), obs_wr, tbl[i].e_wr);
            chk($sformatf("tbl%0d_addr", i), obs_addr, tbl[i].e_addr);
         end
         chk($sformatf("tbl%0d_rvalid", i), obs_rv, tbl[i].e_rv);
         if (tbl[i].e_rv) chk($sformatf("tbl%0d_rdata", i), obs_rd, tbl[i].e_rd);
         chk($sformatf("tbl%0d_done", i), obs_done, tbl[i].e_dn);
         chk($sformatf("tbl%0d_busy", i), obs_busy, tbl[i].e_bz);
      end
      // fetch held high across a refill with a bubble after beat 1
      cycle(0, 1, 7'h40, D0, 1, 7'h01, 1);
      chk("blk_beat0_gnt", obs_gnt, 0);
      cycle(0, 1, 0, D1, 1, 7'h01, 1);
      cycle(0, 0, 0, 0, 1, 7'h01, 1);
      chk("blk_bubble_gnt", obs_gnt, 0);
      cycle(0, 1, 0, D2, 1, 7'h01, 1);
      cycle(0, 1, 0, D3, 1, 7'h01, 1);
      chk("blk_last_gnt", obs_gnt, 0);
      cycle(0, 0, 0, 0, 1, 7'h43, 1);
      chk("blk_done", obs_done, 1);
      chk("blk_done_gnt", obs_gnt, 1);
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 1);
      // 8 back-to-back reads with the consumer stalled for 5 cycles
      issued = 0;
      for (int k = 0; k < 40 && issued < 8; k++) begin
         cycle(0, 0, 0, 0, 1, 7'(48 + issued), !(k >= 3 && k < 8));
         if (obs_gnt) issued++;
      end
      chk("burst_grants", 64'(issued), 8);
      repeat (5) cycle(0, 0, 0, 0, 0, 0, 1);
      chk("burst_drained", obs_busy, 0);
      // reset mid-refill with a buffered read
      cycle(0, 0, 0, 0, 1, 7'h07, 0);
      cycle(0, 1, 7'h55, D0, 0, 0, 0);
      cycle(0, 1, 0, D1, 0, 0, 0);
      cycle(0, 1, 0, D2, 0, 0, 0);
      cycle(1, 0, 0, 0, 1, 7'h07, 1);
      chk("rst_gnt", obs_gnt, 0);
      chk("rst_req", obs_req, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);
      chk("postrst_busy", obs_busy, 0);
      chk("postrst_rvalid", obs_rv, 0);
      chk("postrst_done", obs_done, 0);
      cycle(0, 1, 7'h20, D3, 0, 0, 1);
      chk("rerefill_addr", obs_addr, 7'h20);
      chk("rerefill_wr", obs_wr, 1);
      repeat (3) cycle(0, 1, 0, 64'(cyc), 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      chk("rerefill_done", obs_done, 1);
      // random traffic
      for (int k = 0; k < 600; k++)
         cycle($urandom_range(79) == 0, $urandom_range(2) == 0, 7'($urandom), {$urandom, $urandom},
               $urandom_range(1) == 1, 7'($urandom), $urandom_range(3) != 0);
      repeat (4) cycle(0, 0, 0, 0, 0, 0, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
